// File: rtl/mod_cnt_pkg.sv
// ---------------------------------------------------------------------------
// mod_cnt_pkg
// Shared types and constants for mod_n_event_counter and its event qualifier.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mod_cnt_pkg;

  // Counter FSM state encoding
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // Event qualification modes
  localparam int EVT_LEVEL = 0;
  localparam int EVT_EDGE  = 1;

  // Terminal count loaded at reset unless overridden
  localparam int DEFAULT_TC_DFLT = 9;

endpackage

`default_nettype wire

// File: rtl/mod_n_event_counter_evt_qual.sv
// ---------------------------------------------------------------------------
// evt_qual
// Turns the raw event input into a one-cycle-per-event qualifier: either the
// level itself or its rising edge, selected at elaboration by EDGE_MODE.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module evt_qual
  import mod_cnt_pkg::*;
#(
  parameter int EDGE_MODE = EVT_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_ev
);

  logic r_in_d;

  // Previous-cycle copy of the input; samples every cycle regardless of
  // enable or counter state so an edge is never missed after a gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_in_d <= 1'b0;
    else      r_in_d <= i_in;
  end

  assign o_ev = (EDGE_MODE == EVT_EDGE) ? (i_in & ~r_in_d) : i_in;

endmodule

`default_nettype wire

// File: rtl/mod_n_event_counter.sv
// ---------------------------------------------------------------------------
// mod_n_event_counter
// Counts qualified events and emits a registered one-cycle timeout pulse
// every (tc+1) events. Runtime-loadable terminal count, free-running or
// one-shot operation.
// Optional build macro: MOD_CNT_OVERRUN_EN adds timeout_ack / overrun.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mod_n_event_counter
  import mod_cnt_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEFAULT_TC = DEFAULT_TC_DFLT,
  parameter int EDGE_MODE  = EVT_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in,
  input  logic             oneshot,
  input  logic             tc_load,
  input  logic [WIDTH-1:0] tc_value,
`ifdef MOD_CNT_OVERRUN_EN
  input  logic             timeout_ack,
  output logic             overrun,
`endif
  output logic             timeout,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] c_DEFAULT_TC = WIDTH'(DEFAULT_TC);

  logic             w_ev;
  logic             w_hit;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_tc;
  logic             r_timeout;
  logic             r_done;
  logic [0:0]       r_state;

  evt_qual #(
    .EDGE_MODE (EDGE_MODE)
  ) u_evt_qual (
    .clk  (clk),
    .rst  (rst),
    .i_in (in),
    .o_ev (w_ev)
  );

  // A terminal hit is a counted event landing on tc; a load in the same
  // cycle takes priority and discards the event.
  assign w_hit = (r_state == ST_RUN) & ~tc_load & enable & w_ev & (r_count == r_tc);

  // Counter / FSM update, highest priority first: load, halt, gate, event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= '0;
      r_tc      <= c_DEFAULT_TC;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
      r_state   <= ST_RUN;
    end else if (tc_load) begin
      r_tc      <= tc_value;
      r_count   <= '0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
      r_state   <= ST_RUN;
    end else if (r_state == ST_HALT) begin
      r_timeout <= 1'b0;
    end else if (!enable || !w_ev) begin
      r_timeout <= 1'b0;
    end else if (r_count == r_tc) begin
      r_count   <= '0;
      r_timeout <= 1'b1;
      if (oneshot) begin
        r_state <= ST_HALT;
        r_done  <= 1'b1;
      end
    end else begin
      r_count   <= r_count + 1'b1;
      r_timeout <= 1'b0;
    end
  end

`ifdef MOD_CNT_OVERRUN_EN
  logic r_pending;
  logic r_overrun;

  // pending marks an unacknowledged timeout; a new hit on top of it is an
  // overrun, which stays set until the terminal count is reloaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_hit)            r_pending <= 1'b1;
      else if (timeout_ack) r_pending <= 1'b0;

      if (tc_load)                                   r_overrun <= 1'b0;
      else if (w_hit && r_pending && !timeout_ack)   r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`endif

  assign timeout = r_timeout;
  assign count   = r_count;
  assign tc      = r_tc;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mod_n_event_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_n_event_counter
// Self-checking bench: one level-mode and one edge-mode instance share the
// stimulus; a behavioural model tracks both.
// Optional build macro: MOD_CNT_OVERRUN_EN.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mod_n_event_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_s = 1'b0, in_s = 1'b0, os_s = 1'b0, ld_s = 1'b0, ack_s = 1'b0;
  logic [3:0] tv_s = 4'd0;

  logic [3:0] cnt_l, tc_l, cnt_e, tc_e;
  logic       to_l, done_l, to_e, done_e;
  logic       ovr_l, ovr_e;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: index 0 = level instance, 1 = edge instance
  int unsigned m_cnt [2];
  int unsigned m_tc  [2];
  bit          m_halt[2];
  bit          m_to  [2];
  bit          m_in_d;
  bit          m_pend, m_ovr;

  always #5 clk = ~clk;

  mod_n_event_counter #(.WIDTH(4), .DEFAULT_TC(9), .EDGE_MODE(0)) dut_l (
    .clk(clk), .rst(rst), .enable(en_s), .in(in_s), .oneshot(os_s),
    .tc_load(ld_s), .tc_value(tv_s),
`ifdef MOD_CNT_OVERRUN_EN
    .timeout_ack(ack_s), .overrun(ovr_l),
`endif
    .timeout(to_l), .count(cnt_l), .tc(tc_l), .done(done_l)
  );

  mod_n_event_counter #(.WIDTH(4), .DEFAULT_TC(9), .EDGE_MODE(1)) dut_e (
    .clk(clk), .rst(rst), .enable(en_s), .in(in_s), .oneshot(os_s),
    .tc_load(ld_s), .tc_value(tv_s),
`ifdef MOD_CNT_OVERRUN_EN
    .timeout_ack(ack_s), .overrun(ovr_e),
`endif
    .timeout(to_e), .count(cnt_e), .tc(tc_e), .done(done_e)
  );

`ifndef MOD_CNT_OVERRUN_EN
  assign ovr_l = 1'b0;
  assign ovr_e = 1'b0;
`endif

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_tc[k] = 9; m_halt[k] = 0; m_to[k] = 0;
    end
    m_in_d = 0; m_pend = 0; m_ovr = 0;
  endtask

  // hold reset across one rising edge, then release mid-low-phase
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en_s = 0; in_s = 0; os_s = 0; ld_s = 0; ack_s = 0; tv_s = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // one clock: drive at negedge, advance the model at posedge, settle 1ns
  task automatic cyc(input bit i, input bit en, input bit os, input bit ld,
                     input int tv, input bit ack);
    bit ev, hit;
    @(negedge clk);
    in_s = i; en_s = en; os_s = os; ld_s = ld; tv_s = 4'(tv); ack_s = ack;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      ev  = (k == 0) ? i : (i && !m_in_d);
      hit = 0;
      m_to[k] = 0;
      if (ld) begin
        m_tc[k] = tv; m_cnt[k] = 0; m_halt[k] = 0;
      end else if (!m_halt[k] && en && ev) begin
        if (m_cnt[k] == m_tc[k]) begin
          m_cnt[k] = 0; m_to[k] = 1; hit = 1;
          if (os) m_halt[k] = 1;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      if (k == 0) begin
        if (ld) m_ovr = 0;
        else if (hit && m_pend && !ack) m_ovr = 1;
        if (hit) m_pend = 1;
        else if (ack) m_pend = 0;
      end
    end
    m_in_d = i;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (cnt_l !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cnt_l); end
    n_tests++; if (tc_l !== 4'd9) begin n_fail++; $display("FAIL reset_tc got %0d want 9", tc_l); end
    n_tests++; if (to_l !== 1'b0 || done_l !== 1'b0) begin n_fail++; $display("FAIL reset_flags got to=%b done=%b want 0 0", to_l, done_l); end
    n_tests++; if (cnt_e !== 4'd0 || tc_e !== 4'd9) begin n_fail++; $display("FAIL reset_edge got cnt=%0d tc=%0d want 0 9", cnt_e, tc_e); end
    n_tests++; if (ovr_l !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", ovr_l); end
  endtask

  task automatic test_level_run();
    for (int i = 1; i <= 25; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      n_tests++;
      if (to_l !== ((i % 10) == 0)) begin
        n_fail++; $display("FAIL level_timeout ev=%0d got %b want %b", i, to_l, (i % 10) == 0);
      end
    end
    n_tests++; if (cnt_l !== 4'd5) begin n_fail++; $display("FAIL level_count got %0d want 5", cnt_l); end
  endtask

  task automatic test_tc_change();
    cyc(1, 1, 0, 0, 0, 0);
    n_tests++; if (cnt_l !== 4'd6) begin n_fail++; $display("FAIL tcchg_pre got %0d want 6", cnt_l); end
    cyc(1, 1, 0, 1, 3, 0);
    n_tests++; if (cnt_l !== 4'd0 || tc_l !== 4'd3 || to_l !== 1'b0) begin
      n_fail++; $display("FAIL tcchg_load got cnt=%0d tc=%0d to=%b want 0 3 0", cnt_l, tc_l, to_l);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      n_tests++;
      if (to_l !== ((i % 4) == 0) || cnt_l !== 4'(i % 4)) begin
        n_fail++; $display("FAIL tcchg_run ev=%0d got to=%b cnt=%0d want %b %0d", i, to_l, cnt_l, (i % 4) == 0, i % 4);
      end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    cyc(0, 1, 0, 1, 2, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 1, 1, 0, 0, 0);
      n_tests++;
      if (to_l !== (i == 3) || done_l !== (i >= 3) || cnt_l !== ((i < 3) ? 4'(i) : 4'd0)) begin
        n_fail++; $display("FAIL oneshot ev=%0d got to=%b done=%b cnt=%0d", i, to_l, done_l, cnt_l);
      end
    end
    cyc(0, 1, 0, 1, 2, 0);
    n_tests++; if (done_l !== 1'b0 || cnt_l !== 4'd0) begin n_fail++; $display("FAIL oneshot_reload got done=%b cnt=%0d want 0 0", done_l, cnt_l); end
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    n_tests++; if (cnt_l !== 4'd2 || done_l !== 1'b0) begin n_fail++; $display("FAIL oneshot_resume got cnt=%0d done=%b want 2 0", cnt_l, done_l); end
  endtask

  task automatic test_edge();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      n_tests++; if (cnt_e !== 4'd1 || to_e !== 1'b0) begin n_fail++; $display("FAIL edge_hold cyc=%0d got cnt=%0d to=%b want 1 0", i, cnt_e, to_e); end
    end
    cyc(0, 1, 0, 0, 0, 0);
    for (int p = 1; p <= 10; p++) begin
      cyc(1, 1, 0, 0, 0, 0);
      n_tests++; if (to_e !== (p == 9)) begin n_fail++; $display("FAIL edge_pulse p=%0d got %b want %b", p, to_e, p == 9); end
      cyc(0, 1, 0, 0, 0, 0);
      n_tests++; if (to_e !== 1'b0) begin n_fail++; $display("FAIL edge_low p=%0d got %b want 0", p, to_e); end
    end
    n_tests++; if (cnt_e !== 4'd1) begin n_fail++; $display("FAIL edge_count got %0d want 1", cnt_e); end
  endtask

  task automatic test_gating();
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      n_tests++; if (cnt_l !== 4'd7 || to_l !== 1'b0) begin n_fail++; $display("FAIL gate got cnt=%0d to=%b want 7 0", cnt_l, to_l); end
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++; if (cnt_l !== 4'd0 || tc_l !== 4'd9) begin n_fail++; $display("FAIL async_reset got cnt=%0d tc=%0d want 0 9", cnt_l, tc_l); end
    n_tests++; if (cnt_e !== 4'd0 || to_e !== 1'b0) begin n_fail++; $display("FAIL async_reset_edge got cnt=%0d to=%b want 0 0", cnt_e, to_e); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_boundary();
    do_reset();
    cyc(0, 1, 0, 1, 15, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      n_tests++;
      if (to_l !== (i == 16) || cnt_l !== 4'(i % 16)) begin
        n_fail++; $display("FAIL full_range ev=%0d got to=%b cnt=%0d want %b %0d", i, to_l, cnt_l, i == 16, i % 16);
      end
    end
    cyc(0, 1, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      n_tests++; if (to_l !== 1'b1 || cnt_l !== 4'd0) begin n_fail++; $display("FAIL tc_zero ev=%0d got to=%b cnt=%0d want 1 0", i, to_l, cnt_l); end
    end
  endtask

`ifdef MOD_CNT_OVERRUN_EN
  task automatic test_overrun();
    do_reset();
    cyc(0, 1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    n_tests++; if (ovr_l !== 1'b0) begin n_fail++; $display("FAIL overrun_first got %b want 0", ovr_l); end
    cyc(1, 1, 0, 0, 0, 0);
    n_tests++; if (ovr_l !== 1'b1) begin n_fail++; $display("FAIL overrun_second got %b want 1", ovr_l); end
    cyc(0, 1, 0, 0, 0, 1);
    n_tests++; if (ovr_l !== 1'b1) begin n_fail++; $display("FAIL overrun_ack got %b want 1", ovr_l); end
    cyc(0, 1, 0, 1, 0, 0);
    n_tests++; if (ovr_l !== 1'b0) begin n_fail++; $display("FAIL overrun_load got %b want 0", ovr_l); end
  endtask
`endif

  task automatic test_random();
    bit ri, ren, ros, rld, rack;
    int rtv;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ri   = 1'($urandom % 2);
      ren  = (($urandom % 8) != 0);
      ros  = (($urandom % 16) == 0);
      rld  = (($urandom % 32) == 0);
      rtv  = (($urandom % 4) == 0) ? int'($urandom % 16) : int'($urandom % 4);
      rack = 1'($urandom % 2);
      cyc(ri, ren, ros, rld, rtv, rack);
      n_tests++;
      if (cnt_l !== 4'(m_cnt[0]) || tc_l !== 4'(m_tc[0]) || to_l !== m_to[0] || done_l !== m_halt[0]) begin
        n_fail++; $display("FAIL rand_level c=%0d got cnt=%0d tc=%0d to=%b done=%b want %0d %0d %b %b",
                           c, cnt_l, tc_l, to_l, done_l, m_cnt[0], m_tc[0], m_to[0], m_halt[0]);
      end
      n_tests++;
      if (cnt_e !== 4'(m_cnt[1]) || tc_e !== 4'(m_tc[1]) || to_e !== m_to[1] || done_e !== m_halt[1]) begin
        n_fail++; $display("FAIL rand_edge c=%0d got cnt=%0d tc=%0d to=%b done=%b want %0d %0d %b %b",
                           c, cnt_e, tc_e, to_e, done_e, m_cnt[1], m_tc[1], m_to[1], m_halt[1]);
      end
`ifdef MOD_CNT_OVERRUN_EN
      n_tests++;
      if (ovr_l !== m_ovr) begin n_fail++; $display("FAIL rand_overrun c=%0d got %b want %b", c, ovr_l, m_ovr); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_level_run();
    test_tc_change();
    test_oneshot();
    test_edge();
    test_gating();
    test_boundary();
`ifdef MOD_CNT_OVERRUN_EN
    test_overrun();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
